// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester front end for the single-ported data memory.
// Data port normally wins; fetch is forced through after STARVE_MAX data
// grants in a row while it waits. Memory controls are driven from
// registers, and read data returns to the requester two cycles after
// acceptance.
// Optional feature: define MEM_BOUNDS_CHK_EN to reject any access whose
// addr[21:16] is non-zero. A rejected access raises bus_err, and a
// rejected read returns RD_ERR_DATA.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX  = 4,
  parameter logic [31:0] RD_ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [21:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [21:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [21:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [21:0] mem_addr_q, mem_addr_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        rd_vld_q, rd_vld_d;
  logic        rd_port_q, rd_port_d;
  logic        rd_err_q, rd_err_d;
  logic        bus_err_q, bus_err_d;
  logic        i_rvalid_q, i_rvalid_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        force_fetch;
  logic        accept;
  logic        sel_we;
  logic [21:0] sel_addr;
  logic        addr_oob;
  logic [31:0] read_word;

  assign force_fetch = i_req && (starve_cnt_q == STARVE_LIM);

  // Grant: data port first unless fetch has waited out its starvation budget
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (d_req && !force_fetch) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  assign accept   = i_gnt | d_gnt;
  assign sel_we   = d_gnt & d_we;
  assign sel_addr = d_gnt ? d_addr : i_addr;

`ifdef MEM_BOUNDS_CHK_EN
  assign addr_oob = accept && (sel_addr[21:16] != 6'd0);
`else
  assign addr_oob = 1'b0;
`endif

  // Starvation counter: counts data grants that overtake a waiting fetch
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_req || i_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (d_gnt && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Issue stage: register memory controls plus the read tag for the winner
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    rd_vld_d    = 1'b0;
    rd_port_d   = 1'b0;
    rd_err_d    = 1'b0;
    bus_err_d   = 1'b0;
    if (accept) begin
      mem_addr_d = sel_addr;
      if (d_gnt) begin
        mem_wdata_d = d_wdata;
      end
      mem_re_d  = ~sel_we & ~addr_oob;
      mem_we_d  = sel_we & ~addr_oob;
      rd_vld_d  = ~sel_we;
      rd_port_d = d_gnt;
      rd_err_d  = addr_oob;
      bus_err_d = addr_oob;
    end
  end

  assign read_word = rd_err_q ? RD_ERR_DATA : mem_rdata;

  // Return stage: steer captured read data to the port named by the tag
  always_comb begin
    i_rvalid_d = rd_vld_q & ~rd_port_q;
    d_rvalid_d = rd_vld_q & rd_port_q;
    i_rdata_d  = i_rvalid_d ? read_word : i_rdata_q;
    d_rdata_d  = d_rvalid_d ? read_word : d_rdata_q;
  end

  // State registers; reset also flushes anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
      mem_addr_q   <= 22'd0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 32'd0;
      rd_vld_q     <= 1'b0;
      rd_port_q    <= 1'b0;
      rd_err_q     <= 1'b0;
      bus_err_q    <= 1'b0;
      i_rvalid_q   <= 1'b0;
      i_rdata_q    <= 32'd0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= 32'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_vld_q     <= rd_vld_d;
      rd_port_q    <= rd_port_d;
      rd_err_q     <= rd_err_d;
      bus_err_q    <= bus_err_d;
      i_rvalid_q   <= i_rvalid_d;
      i_rdata_q    <= i_rdata_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rvalid  = i_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

`ifdef MEM_BOUNDS_CHK_EN
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a directed stimulus process queues the
// expected read returns, and a monitor pops and compares them whenever
// a port raises rvalid. The memory model writes on the falling edge, so
// a read issued in the next cycle sees the new data.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [21:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [21:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [21:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        bus_err;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mem [0:255];
  logic        exp_i;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: combinational read while mem_re, write in the low phase
  assign mem_rdata = (mem_re === 1'b1) ? mem[mem_addr[7:0]] : 32'h0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %h required %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, {31'b0, actual}, {31'b0, expected});
  endtask

  task automatic checkGnt(input logic ei, input logic ed);
    checkBit("i_gnt", i_gnt, ei);
    checkBit("d_gnt", d_gnt, ed);
  endtask

  task automatic checkMem(input logic ere, input logic ewe, input logic [21:0] ea,
                          input logic [31:0] ewd);
    checkBit("mem_re", mem_re, ere);
    checkBit("mem_we", mem_we, ewe);
    if (ere || ewe) checkOutput("mem_addr", {10'b0, mem_addr}, {10'b0, ea});
    if (ewe) checkOutput("mem_wdata", mem_wdata, ewd);
  endtask

  task automatic pushExp(input logic p, input logic [31:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic ir, input logic [21:0] ia, input logic dr,
                               input logic dw, input logic [21:0] da, input logic [31:0] dd);
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
    #1;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic popCheck(input logic port, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL unexpected_rvalid: actual port %0d data %h required no return", port, data);
    end else begin
      e = sb.pop_front();
      checkBit("rvalid_port", port, e.port);
      checkOutput("rdata", data, e.data);
    end
  endtask

  // Monitor: compare every read return against the scoreboard head
  always @(negedge clk) begin
    if (i_rvalid === 1'b1) popCheck(1'b0, i_rdata);
    if (d_rvalid === 1'b1) popCheck(1'b1, d_rdata);
    if (mem_re === 1'b1 || mem_we === 1'b1)
      checkBit("re_we_exclusive", mem_re & mem_we, 1'b0);
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    mem[8'h10] = 32'h12345678;
    rst = 1'b1;
    applyStimulus(1'b1, 22'h10, 1'b1, 1'b0, 22'h20, 32'h0);

    // Reset held with both requests up: no grants, everything zero
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkGnt(1'b0, 1'b0);
      checkBit("rst_i_rvalid", i_rvalid, 1'b0);
      checkBit("rst_d_rvalid", d_rvalid, 1'b0);
      checkOutput("rst_i_rdata", i_rdata, 32'h0);
      checkOutput("rst_d_rdata", d_rdata, 32'h0);
      checkMem(1'b0, 1'b0, 22'h0, 32'h0);
      checkOutput("rst_mem_addr", {10'b0, mem_addr}, 32'h0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
      checkBit("rst_bus_err", bus_err, 1'b0);
    end

    // Release into continuous contention: d,d,d,d,i repeating
    rst = 1'b0;
    applyStimulus(1'b1, 22'h10, 1'b1, 1'b1, 22'h30, 32'h11111111);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        if (((k - 1) % 5) == 4) checkMem(1'b1, 1'b0, 22'h10, 32'h0);
        else                    checkMem(1'b0, 1'b1, 22'h30, 32'h11111111);
      end
      exp_i = ((k % 5) == 4);
      checkGnt(exp_i, !exp_i);
      if (exp_i) pushExp(1'b0, 32'h12345678);
      nextCycle();
    end
    checkMem(1'b1, 1'b0, 22'h10, 32'h0);
    applyStimulus(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 32'h0);
    checkGnt(1'b0, 1'b0);
    nextCycle();
    checkMem(1'b0, 1'b0, 22'h0, 32'h0);
    checkOutput("hold_mem_addr", {10'b0, mem_addr}, 32'h10);

    // Write then read the same address in consecutive cycles
    applyStimulus(1'b0, 22'h0, 1'b1, 1'b1, 22'h20, 32'hCAFEF00D);
    checkGnt(1'b0, 1'b1);
    nextCycle();
    checkMem(1'b0, 1'b1, 22'h20, 32'hCAFEF00D);
    applyStimulus(1'b0, 22'h0, 1'b1, 1'b0, 22'h20, 32'h0);
    checkGnt(1'b0, 1'b1);
    pushExp(1'b1, 32'hCAFEF00D);
    nextCycle();
    checkMem(1'b1, 1'b0, 22'h20, 32'h0);

    // Both read: data wins, then fetch alone
    applyStimulus(1'b1, 22'h30, 1'b1, 1'b0, 22'h10, 32'h0);
    checkGnt(1'b0, 1'b1);
    pushExp(1'b1, 32'h12345678);
    nextCycle();
    checkMem(1'b1, 1'b0, 22'h10, 32'h0);
    applyStimulus(1'b1, 22'h30, 1'b0, 1'b0, 22'h0, 32'h0);
    checkGnt(1'b1, 1'b0);
    pushExp(1'b0, 32'h11111111);
    nextCycle();
    checkMem(1'b1, 1'b0, 22'h30, 32'h0);

    // Fetch loses to a write, then withdraws before being granted
    applyStimulus(1'b1, 22'h40, 1'b1, 1'b1, 22'h50, 32'h55555555);
    checkGnt(1'b0, 1'b1);
    nextCycle();
    checkMem(1'b0, 1'b1, 22'h50, 32'h55555555);
    applyStimulus(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 32'h0);
    checkGnt(1'b0, 1'b0);
    nextCycle();
    checkMem(1'b0, 1'b0, 22'h0, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("i_rdata_hold", i_rdata, 32'h11111111);
    checkOutput("d_rdata_hold", d_rdata, 32'h12345678);

    // Reset arriving while a fetch read is in flight
    applyStimulus(1'b1, 22'h10, 1'b0, 1'b0, 22'h0, 32'h0);
    checkGnt(1'b1, 1'b0);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b1, 22'h10, 1'b1, 1'b0, 22'h0, 32'h0);
    checkGnt(1'b0, 1'b0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 32'h0);
    checkBit("midrst_i_rvalid", i_rvalid, 1'b0);
    checkOutput("midrst_i_rdata", i_rdata, 32'h0);
    checkOutput("midrst_d_rdata", d_rdata, 32'h0);

`ifdef MEM_BOUNDS_CHK_EN
    // Out-of-range read: granted, not issued, error pulse and error data
    applyStimulus(1'b0, 22'h0, 1'b1, 1'b0, 22'h010000, 32'h0);
    checkGnt(1'b0, 1'b1);
    pushExp(1'b1, 32'hDEADBEEF);
    nextCycle();
    checkMem(1'b0, 1'b0, 22'h0, 32'h0);
    checkBit("bus_err_pulse", bus_err, 1'b1);
    applyStimulus(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 32'h0);
    nextCycle();
    checkBit("bus_err_clear", bus_err, 1'b0);
`else
    // Without checking, the full address passes straight through
    applyStimulus(1'b0, 22'h0, 1'b1, 1'b1, 22'h3F0040, 32'hA5A5A5A5);
    checkGnt(1'b0, 1'b1);
    nextCycle();
    checkMem(1'b0, 1'b1, 22'h3F0040, 32'hA5A5A5A5);
    checkBit("bus_err_tied", bus_err, 1'b0);
    applyStimulus(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 32'h0);
    nextCycle();
`endif

    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("sb_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester front end for the single-ported main data memory. Arbitrates between the instruction-fetch port (read-only) and the data port (read/write), and drives the memory's address, read-enable, write-enable and write-data inputs from registers. Captures the memory's read data and returns it to the winning port with a fixed two-cycle latency. Guarantees that memory read and write are never requested in the same cycle.

## Interface
- STARVE_MAX, 4, consecutive data-port grants allowed while i_req is pending before fetch is forced through (1..15)
- RD_ERR_DATA, 32'hDEADBEEF, read data returned for a rejected out-of-range read (MEM_BOUNDS_CHK_EN only)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch read request; held with i_addr until i_gnt
- i_addr  in  22  fetch word address
- i_gnt  out  1  combinational; request accepted this cycle
- i_rvalid  out  1  registered; i_rdata valid this cycle
- i_rdata  out  32  fetch read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  22  data word address
- d_wdata  in  32  write data
- d_gnt  out  1  combinational; request accepted this cycle
- d_rvalid  out  1  registered; d_rdata valid this cycle (reads only)
- d_rdata  out  32  data read data
- mem_addr  out  22  registered memory address
- mem_re  out  1  registered memory read enable
- mem_we  out  1  registered memory write enable
- mem_wdata  out  32  registered memory write data
- mem_rdata  in  32  memory read data, stable by the end of the cycle mem_re is high
- bus_err  out  1  registered one-cycle pulse on a rejected access

## Operation
- At most one of i_gnt, d_gnt high per cycle; both 0 while rst is high.
- Priority: data port wins when both request, except when starve_cnt == STARVE_MAX and i_req high; then fetch wins.
- starve_cnt (4 bits): +1 on each d_gnt while i_req is high; cleared on i_gnt, on any cycle with i_req low, and on rst. Saturates at STARVE_MAX.
- Accepted request in cycle N: mem_addr/mem_re/mem_we/mem_wdata load at the edge ending N and are driven in cycle N+1. mem_re = ~we and mem_we = we, so both are never high together. With no acceptance in N, mem_re = mem_we = 0 in N+1; mem_addr and mem_wdata hold.
- Pipeline tag (valid, port) travels with each read. At the edge ending N+1, mem_rdata loads into the tagged port's rdata register and that port's rvalid pulses in N+2. The other port's rdata holds.
- Writes produce no rvalid.
- Back-to-back acceptance is allowed every cycle, so throughput is one access per cycle.
- Read after write to the same address in consecutive cycles returns the new data, because the memory write happens in the low phase of N+1, before the read.
- rst high at any edge clears the pipeline: in-flight reads never produce rvalid, and in-flight writes are not issued.

## Timing
- Reset values: i_gnt = d_gnt = 0, i_rvalid = d_rvalid = 0, i_rdata = d_rdata = 0, mem_addr = 0, mem_re = mem_we = 0, mem_wdata = 0, bus_err = 0, starve_cnt = 0.
- Grant is combinational from req, the arbitration state and rst. No combinational path from req to any mem_* output.
- Read latency: req accepted in N, rvalid in N+2.
- Write latency: mem_we high in N+1.
- If a requester drops req before gnt, the request is withdrawn with no side effect.

## Configuration
- MEM_BOUNDS_CHK_EN defined:
  - An accepted request with addr[21:16] != 0 is granted normally, but mem_re and mem_we stay 0 in N+1.
  - bus_err pulses in N+1.
  - An out-of-range read still returns rvalid in N+2, with rdata = RD_ERR_DATA.
- MEM_BOUNDS_CHK_EN undefined:
  - No checking; the full 22-bit address passes through.
  - bus_err is tied to 0.

## Test plan
- Reset then idle: rst high 3 cycles with i_req = d_req = 1 -> no gnt, all outputs 0. Release -> d_gnt in the first cycle after rst.
- Fetch read: mem[0x10] = 32'h12345678, i_req with i_addr = 0x10 in cycle N -> i_gnt in N, mem_re = 1 and mem_addr = 0x10 in N+1, i_rvalid with i_rdata = 32'h12345678 in N+2.
- Write then read: d write 0x20 = 32'hCAFEF00D in N, d read 0x20 in N+1 -> mem_we in N+1, mem_re in N+2, d_rvalid with 32'hCAFEF00D in N+3. mem_re and mem_we are never both 1.
- Starvation: i_req and d_req held high continuously -> grant pattern d, d, d, d, i, d, d, d, d, i with STARVE_MAX = 4.
- Reset mid-read: i read accepted in N, rst high in N+1 -> no i_rvalid in N+2; i_rdata stays 0.
- With MEM_BOUNDS_CHK_EN: d read of addr 22'h010000 -> d_gnt, mem_re = 0, bus_err pulses in N+1, d_rvalid with 32'hDEADBEEF in N+2.
